// File: rtl/truth_table_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : truth_table_checker_pkg
//  Purpose  : Shared types and constants for the truth-table checker:
//             FSM state encoding, default expected truth table, number of
//             vectors in a sweep and the error-counter width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package truth_table_checker_pkg;

    // Expected z for each index {x_2,x_1,x_0}; bit i is the answer for index i.
    localparam logic [7:0] TRUTH_TABLE_DEFAULT = 8'b00111001;

    localparam int VEC_COUNT = 8;
    localparam int ERR_W     = 4;
    localparam int TAKT_W    = 4;
    localparam int TIMER_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

endpackage : truth_table_checker_pkg
`default_nettype wire

// File: rtl/truth_table_checker_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : settle_timer
//  Purpose  : Loadable down-counter measuring the settle interval between
//             driving a vector and sampling the response.
//  Ports    : clock      - rising-edge clock
//             reset      - asynchronous active-high reset (count -> 0)
//             load_i     - load count with load_val_i (has priority)
//             load_val_i - value to load
//             en_i       - decrement while non-zero
//             expired_o  - count has reached zero
//  Revision : 1.0 - initial release
// ============================================================================
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule : settle_timer
`default_nettype wire

// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
//  Module   : truth_table_checker
//  Purpose  : Applies all eight 3-bit input vectors to an external logic
//             block, waits SETTLE cycles per vector, compares the returned z
//             against TRUTH_TABLE and reports mismatches.
//  Ports    : clock, reset (async, active-high), start (begin a sweep),
//             z (response of logic under test),
//             x_0/x_1/x_2 (stimulus bits = takt[2:0]), takt (vector index),
//             error (one-cycle mismatch pulse), err_count (mismatches this
//             sweep, saturating at 8), busy, done, pass.
//  Config   : CHECKER_STOP_ON_ERROR_EN - when defined, the first mismatch
//             ends the sweep, leaving takt at the failing index.
//  Revision : 1.0 - initial release
// ============================================================================
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter logic [7:0] TRUTH_TABLE = TRUTH_TABLE_DEFAULT,
    parameter int         SETTLE      = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              z,
    output logic              x_0,
    output logic              x_1,
    output logic              x_2,
    output logic [TAKT_W-1:0] takt,
    output logic              error,
    output logic [ERR_W-1:0]  err_count,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    // The timer is loaded in DRIVE and the SETTLE state lasts load+1 cycles.
    localparam logic [TIMER_W-1:0] C_SETTLE_LOAD = TIMER_W'(SETTLE - 1);
    localparam logic [ERR_W-1:0]   C_ERR_MAX     = ERR_W'(VEC_COUNT);
    localparam logic [TAKT_W-1:0]  C_TAKT_LAST   = TAKT_W'(VEC_COUNT - 1);

    state_e              state_q, state_d;
    logic [TAKT_W-1:0]   takt_q, takt_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                error_q, error_d;

    logic                w_tmr_load;
    logic                w_tmr_en;
    logic                w_tmr_expired;
    logic                w_mismatch;

    settle_timer #(
        .W (TIMER_W)
    ) u_settle_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (w_tmr_load),
        .load_val_i (C_SETTLE_LOAD),
        .en_i       (w_tmr_en),
        .expired_o  (w_tmr_expired)
    );

    assign w_mismatch = (z != TRUTH_TABLE[takt_q[2:0]]);

    always_comb begin
        state_d    = state_q;
        takt_d     = takt_q;
        err_d      = err_q;
        error_d    = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_en   = 1'b0;

        case (state_q)
            // A new sweep can be launched from IDLE or from a finished sweep.
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    takt_d  = '0;
                    err_d   = '0;
                end
            end

            S_DRIVE: begin
                w_tmr_load = 1'b1;
                state_d    = S_SETTLE;
            end

            S_SETTLE: begin
                if (w_tmr_expired) begin
                    state_d = S_SAMPLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            S_SAMPLE: begin
                if (w_mismatch) begin
                    error_d = 1'b1;
                    if (err_q != C_ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                end
`ifdef CHECKER_STOP_ON_ERROR_EN
                if (w_mismatch || (takt_q == C_TAKT_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRIVE;
                    takt_d  = takt_q + 1'b1;
                end
`else
                if (takt_q == C_TAKT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRIVE;
                    takt_d  = takt_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            takt_q  <= '0;
            err_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            takt_q  <= takt_d;
            err_q   <= err_d;
            error_q <= error_d;
        end
    end

    // Status outputs decode registered state only, so reset clears them
    // without waiting for a clock edge.
    assign takt      = takt_q;
    assign x_0       = takt_q[0];
    assign x_1       = takt_q[1];
    assign x_2       = takt_q[2];
    assign error     = error_q;
    assign err_count = err_q;
    assign busy      = (state_q == S_DRIVE) || (state_q == S_SETTLE) ||
                       (state_q == S_SAMPLE);
    assign done      = (state_q == S_DONE);
    assign pass      = (state_q == S_DONE) && (err_q == '0);

endmodule : truth_table_checker
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_truth_table_checker
//  Purpose  : Self-checking bench for truth_table_checker. The logic under
//             test is modelled as the expected truth table XOR a fault mask;
//             expected timing, error pulses and counts are derived from the
//             mask with plain arithmetic.
//  Config   : honours CHECKER_STOP_ON_ERROR_EN in the reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       z;
    logic       x_0, x_1, x_2;
    logic [3:0] takt;
    logic       error;
    logic [3:0] err_count;
    logic       busy, done, pass;

    logic [7:0] tt   = 8'b00111001;
    logic [7:0] mask = 8'h00;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign z = tt[{x_2, x_1, x_0}] ^ mask[{x_2, x_1, x_0}];

    truth_table_checker #(
        .TRUTH_TABLE (8'b00111001),
        .SETTLE      (2)
    ) dut (
        .clock     (clk),
        .reset     (rst),
        .start     (start),
        .z         (z),
        .x_0       (x_0),
        .x_1       (x_1),
        .x_2       (x_2),
        .takt      (takt),
        .error     (error),
        .err_count (err_count),
        .busy      (busy),
        .done      (done),
        .pass      (pass)
    );

    // One full sweep with fault mask m. Cycle n counts rising edges, the
    // edge that samples start being n=1. Vector k occupies n=4k+1..4k+4 and
    // its mismatch pulse appears at n=4k+5.
    task automatic run_sweep(input logic [7:0] m, input int repulse_at, input string tag);
        int   n, dexp, first, nerr, k, etakt;
        logic eerr;
        mask  = m;
        first = -1;
        for (int i = 0; i < 8; i++) if (m[i] && first < 0) first = i;
`ifdef CHECKER_STOP_ON_ERROR_EN
        dexp = (first < 0) ? 33 : 4 * first + 5;
`else
        dexp = 33;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 1;
        nerr  = 0;
        while (n <= dexp) begin
            k    = (n - 5) / 4;
            eerr = (n >= 5) && (((n - 5) % 4) == 0) && (k < 8) && m[k];
            if (eerr) nerr++;
            if (n < dexp)          etakt = (n - 1) / 4;
            else if (dexp != 33)   etakt = first;
            else                   etakt = 7;

            checks++;
            if (error !== eerr) begin
                failures++;
                $display("FAIL %s error n=%0d got=%b exp=%b", tag, n, error, eerr);
            end
            checks++;
            if (busy !== (n < dexp)) begin
                failures++;
                $display("FAIL %s busy n=%0d got=%b exp=%b", tag, n, busy, (n < dexp));
            end
            checks++;
            if (done !== (n == dexp)) begin
                failures++;
                $display("FAIL %s done n=%0d got=%b exp=%b", tag, n, done, (n == dexp));
            end
            checks++;
            if (takt !== 4'(etakt) || {x_2, x_1, x_0} !== 3'(etakt)) begin
                failures++;
                $display("FAIL %s takt n=%0d got=%0d x=%b exp=%0d", tag, n, takt, {x_2, x_1, x_0}, etakt);
            end
            checks++;
            if (err_count !== 4'(nerr)) begin
                failures++;
                $display("FAIL %s err_count n=%0d got=%0d exp=%0d", tag, n, err_count, nerr);
            end
            checks++;
            if (pass !== ((n == dexp) && (nerr == 0))) begin
                failures++;
                $display("FAIL %s pass n=%0d got=%b exp=%b", tag, n, pass, ((n == dexp) && (nerr == 0)));
            end
            if (n == repulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        // One cycle into DONE: everything held, no stray error pulse.
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || takt !== 4'(etakt) ||
            err_count !== 4'(nerr) || pass !== (nerr == 0)) begin
            failures++;
            $display("FAIL %s hold got done=%b busy=%b error=%b takt=%0d cnt=%0d pass=%b exp takt=%0d cnt=%0d",
                     tag, done, busy, error, takt, err_count, pass, etakt, nerr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({takt, x_2, x_1, x_0, error, err_count, busy, done, pass} !== 15'd0) begin
            failures++;
            $display("FAIL reset_state got takt=%0d x=%b err=%b cnt=%0d busy=%b done=%b pass=%b exp all 0",
                     takt, {x_2, x_1, x_0}, error, err_count, busy, done, pass);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_pass_sweep();
        run_sweep(8'h00, 0, "pass");
    endtask

    task automatic test_inverted();
        run_sweep(8'hFF, 0, "inverted");
    endtask

    task automatic test_single_fault();
        run_sweep(8'h08, 0, "fault3");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            run_sweep(8'($urandom), 0, "random");
        end
    endtask

    task automatic test_start_ignored();
        // n=10 lies in vector 2; the following edge sees start while busy.
        run_sweep(8'h00, 10, "repulse");
    endtask

    task automatic test_back_to_back();
        run_sweep(8'hFF, 0, "b2b_fail");
        run_sweep(8'h00, 0, "b2b_clean");
    endtask

    task automatic test_reset_midsweep();
        int budget;
        mask  = 8'h00;
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        budget = 0;
        while (takt !== 4'd4 && budget < 40) begin
            @(posedge clk); #1;
            budget++;
        end
        checks++;
        if (takt !== 4'd4) begin
            failures++;
            $display("FAIL midreset_reach takt got=%0d exp=4", takt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({takt, x_2, x_1, x_0, error, err_count, busy, done, pass} !== 15'd0) begin
            failures++;
            $display("FAIL midreset_async got takt=%0d x=%b err=%b cnt=%0d busy=%b done=%b pass=%b exp all 0",
                     takt, {x_2, x_1, x_0}, error, err_count, busy, done, pass);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midreset_idle got done=%b busy=%b exp 0 0", done, busy);
            end
        end
        run_sweep(8'h00, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_pass_sweep();
        test_inverted();
        test_single_fault();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_reset_midsweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule : tb_truth_table_checker
`default_nettype wire

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 SHALL have parameter TRUTH_TABLE, default 8'b00111001: expected z for each 3-bit input index {x_2,x_1,x_0}.
REQ-002 SHALL have parameter SETTLE, default 2: wait cycles between driving a vector and sampling z; legal range 1..15.
REQ-003 SHALL have port clock  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1: request to begin one exhaustive sweep.
REQ-006 SHALL have port z  input  1: output of the logic under test.
REQ-007 SHALL have ports x_0, x_1, x_2  output  1 each: stimulus bits, equal to takt[0], takt[1], takt[2].
REQ-008 SHALL have port takt  output  4: current vector index, 0..7.
REQ-009 SHALL have port error  output  1: one-cycle pulse on each mismatch.
REQ-010 SHALL have port err_count  output  4: mismatches in the current or most recent sweep.
REQ-011 SHALL have ports busy, done, pass  output  1 each: sweep running; sweep finished; finished with err_count==0.

Function
REQ-012 SHALL implement FSM states IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-013 IDLE: start=1 -> DRIVE with takt=0 and err_count=0; start=0 -> stay in IDLE.
REQ-014 DRIVE: exactly 1 cycle; x_* already reflect takt; -> SETTLE.
REQ-015 SETTLE: exactly SETTLE cycles, counted by a settle timer; -> SAMPLE.
REQ-016 SAMPLE: exactly 1 cycle; z compared against TRUTH_TABLE[takt[2:0]].
REQ-017 On mismatch, error SHALL be 1 in the cycle after SAMPLE, and err_count SHALL increment, saturating at 8.
REQ-018 After SAMPLE: takt==7 -> DONE; else -> DRIVE with takt+1.
REQ-019 Each vector SHALL take SETTLE+2 cycles; done SHALL rise 8*(SETTLE+2)+1 cycles after the edge that samples start (33 at default).
REQ-020 busy SHALL be 1 in DRIVE, SETTLE and SAMPLE, and 0 otherwise.
REQ-021 DONE: done=1; pass=(err_count==0); takt held at 7; err_count held.
REQ-022 DONE with start=1 SHALL begin a new sweep exactly as from IDLE; start while busy SHALL be ignored.
REQ-023 error SHALL never be high outside the cycle following SAMPLE.

Reset
REQ-024 reset=1 SHALL force, immediately and regardless of clock: state IDLE; takt=0; x_*=0; err_count=0; error, busy, done, pass all 0; settle timer 0.
REQ-025 A reset during a sweep SHALL abort it with no done pulse; the next start SHALL run a full sweep from takt=0.

Configuration
REQ-026 With macro CHECKER_STOP_ON_ERROR_EN defined, the first mismatch SHALL move SAMPLE -> DONE, leaving takt at the failing index, err_count=1 and pass=0.
REQ-027 Without CHECKER_STOP_ON_ERROR_EN, all 8 vectors SHALL always be applied.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the default TRUTH_TABLE constant, the vector count (8) and the err_count width (4).
REQ-029 The wait counter SHALL be a sub-module, settle_timer (load, count-down, expired flag).

Verification
REQ-030 z driven as TRUTH_TABLE[{x_2,x_1,x_0}], SETTLE=2, start pulse -> done=1 at cycle 33, err_count=0, pass=1, no error pulses.
REQ-031 z = inverted model -> 8 error pulses, err_count=8, pass=0.
REQ-032 z = model except index 3 inverted -> exactly one error pulse, in the cycle after SAMPLE with takt=3; err_count=1.
REQ-033 reset asserted while takt=4 -> all outputs 0 asynchronously; a new start gives a clean sweep with the REQ-030 result.
REQ-034 start re-pulsed at takt=2 -> ignored, done still at cycle 33; start in DONE -> new sweep, err_count cleared.
REQ-035 With CHECKER_STOP_ON_ERROR_EN and inverted z -> done at cycle 5 (SETTLE=2), takt=0, err_count=1, pass=0.
